// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory, then releases the core.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, FLUSH, DONE} state_t;
  state_t            state;
  logic [LEN_W-1:0]  len;
  logic [ADDR_W:0]   wcnt;
  logic [1:0]        lane;
  logic [23:0]       acc;
  logic [LEN_W-1:0]  n;
  logic              xfer, last;
  assign xfer = rx_valid & rx_ready;
  assign n    = LEN_W'({rx_data, len[7:0]});
  // wcnt is one bit wider than the address so a full 1024-word image compares correctly
  assign last = (LEN_W'(wcnt) + LEN_W'(1)) == len;
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      len      <= '0;
      wcnt     <= '0;
      lane     <= '0;
      acc      <= '0;
      rx_ready <= 1'b0;
      im_we    <= 1'b0;
      im_addr  <= '0;
      im_wdata <= '0;
      core_rst <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      im_we <= 1'b0;
      case (state)
        IDLE, DONE: if (start) begin
          state    <= LEN0;
          rx_ready <= 1'b1;
          busy     <= 1'b1;
          done     <= 1'b0;
          core_rst <= 1'b1;
          err      <= 1'b0;
          wcnt     <= '0;
          lane     <= '0;
        end
        LEN0: if (xfer) begin
          len[7:0] <= rx_data;
          state    <= LEN1;
        end
        LEN1: if (xfer) begin
          len <= n;
          if (n == '0) begin
            state    <= DONE;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            core_rst <= 1'b0;
          end else if (n > LEN_W'(2 ** ADDR_W)) begin
            state    <= IDLE;
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            err      <= 1'b1;
          end else begin
            state <= DATA;
          end
        end
        DATA: if (xfer) begin
          if (lane == 2'd3) begin
            im_we    <= 1'b1;
            im_wdata <= {rx_data, acc};
            im_addr  <= wcnt[ADDR_W-1:0];
            wcnt     <= wcnt + 1'b1;
            lane     <= '0;
            if (last) begin
              state    <= FLUSH;
              rx_ready <= 1'b0;
            end
          end else begin
            acc[{lane, 3'b000} +: 8] <= rx_data;
            lane <= lane + 1'b1;
          end
        end
        FLUSH: begin
          state    <= DONE;
          busy     <= 1'b0;
          done     <= 1'b1;
          core_rst <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven cycle vectors plus directed multi-cycle sequences for imem_loader.
module tb_imem_loader;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_ready, im_we, core_rst, busy, done, err;
  logic [9:0] im_addr;
  logic [31:0] im_wdata;
  int tests = 0, fails = 0;
  logic [41:0] wq[$];

  imem_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (im_we) wq.push_back({im_addr, im_wdata});

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic st, vl;
    logic [7:0] d;
    logic rdy, we;
    logic [9:0] addr;
    logic [31:0] wd;
    logic crst, bsy, dn, er;
  } vec_t;

  function automatic vec_t mk(logic st, logic vl, logic [7:0] d, logic rdy, logic we,
                              logic [9:0] addr, logic [31:0] wd, logic crst, logic bsy,
                              logic dn, logic er);
    vec_t v;
    v.st = st; v.vl = vl; v.d = d; v.rdy = rdy; v.we = we; v.addr = addr; v.wd = wd;
    v.crst = crst; v.bsy = bsy; v.dn = dn; v.er = er;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] outs();
    return {rx_ready, im_we, im_addr, im_wdata, core_rst, busy, done, err};
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input int gap, input bit chk);
    bit acc;
    for (int i = 0; i < gap; i++) begin
      rx_valid = 1'b0;
      @(posedge clk); #1;
      if (chk) check("gap_rx_ready", 64'(rx_ready), 64'd1);
    end
    rx_valid = 1'b1;
    rx_data = d;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      acc = rx_ready;
      @(posedge clk); #1;
    end
    if (!acc) check("accept_timeout", 64'd0, 64'd1);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap, input bit chk);
    for (int b = 0; b < 4; b++) send(w[8*b +: 8], gap, chk);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (done) ok = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check("done_reached", 64'(ok), 64'd1);
  endtask

  vec_t tv[21];

  initial begin
    tv[0]  = mk(1, 0, 8'h00, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[1]  = mk(0, 1, 8'h02, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[2]  = mk(0, 1, 8'h00, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[3]  = mk(0, 1, 8'h78, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[4]  = mk(0, 1, 8'h56, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[5]  = mk(0, 1, 8'h34, 1, 0, 10'd0, 32'h0,        1, 1, 0, 0);
    tv[6]  = mk(0, 1, 8'h12, 1, 1, 10'd0, 32'h12345678, 1, 1, 0, 0);
    tv[7]  = mk(0, 1, 8'hEF, 1, 0, 10'd0, 32'h12345678, 1, 1, 0, 0);
    tv[8]  = mk(0, 1, 8'hBE, 1, 0, 10'd0, 32'h12345678, 1, 1, 0, 0);
    tv[9]  = mk(0, 1, 8'hAD, 1, 0, 10'd0, 32'h12345678, 1, 1, 0, 0);
    tv[10] = mk(0, 1, 8'hDE, 0, 1, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[11] = mk(0, 0, 8'h00, 0, 0, 10'd1, 32'hDEADBEEF, 0, 0, 1, 0);
    tv[12] = mk(0, 1, 8'h55, 0, 0, 10'd1, 32'hDEADBEEF, 0, 0, 1, 0);
    tv[13] = mk(1, 0, 8'h00, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[14] = mk(0, 1, 8'h01, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[15] = mk(0, 1, 8'h00, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[16] = mk(0, 1, 8'h04, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[17] = mk(0, 1, 8'h03, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[18] = mk(0, 1, 8'h02, 1, 0, 10'd1, 32'hDEADBEEF, 1, 1, 0, 0);
    tv[19] = mk(0, 1, 8'h01, 0, 1, 10'd0, 32'h01020304, 1, 1, 0, 0);
    tv[20] = mk(0, 0, 8'h00, 0, 0, 10'd0, 32'h01020304, 0, 0, 1, 0);

    // reset dominates start and a valid stream byte
    rst = 1'b1; start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAA;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("reset_hold", 64'(outs()), {16'h0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    end
    rst = 1'b0; start = 1'b0; rx_valid = 1'b0;

    // two-word load then reload from DONE, cycle by cycle
    for (int i = 0; i < 21; i++) begin
      start = tv[i].st; rx_valid = tv[i].vl; rx_data = tv[i].d;
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({tv[i].rdy, tv[i].we, tv[i].addr, tv[i].wd, tv[i].crst, tv[i].bsy, tv[i].dn, tv[i].er}));
    end
    start = 1'b0; rx_valid = 1'b0;

    // backpressure: two idle cycles before every byte
    wq.delete();
    pulse_start();
    send(8'h02, 2, 1); send(8'h00, 2, 1);
    send_word(32'h12345678, 2, 1);
    send_word(32'hDEADBEEF, 2, 0);
    wait_done();
    check("gap_writes", 64'(wq.size()), 64'd2);
    if (wq.size() == 2) begin
      check("gap_w0", 64'(wq[0]), {22'h0, 10'd0, 32'h12345678});
      check("gap_w1", 64'(wq[1]), {22'h0, 10'd1, 32'hDEADBEEF});
    end

    // empty header
    wq.delete();
    pulse_start();
    send(8'h00, 0, 0); send(8'h00, 0, 0);
    check("n0_status", 64'({done, core_rst, busy, rx_ready, err}), 64'b10000);
    @(posedge clk); #1;
    check("n0_writes", 64'(wq.size()), 64'd0);

    // oversize header
    pulse_start();
    send(8'h01, 0, 0); send(8'h04, 0, 0);
    check("over_status", 64'({err, busy, core_rst, rx_ready, done}), 64'b10100);
    @(posedge clk); #1;
    check("over_idle", 64'({err, busy, core_rst, rx_ready, done, im_we}), 64'b101000);
    check("over_writes", 64'(wq.size()), 64'd0);
    pulse_start();
    check("err_cleared", 64'({err, busy}), 64'b01);

    // full 1024-word image (loader already in LEN0)
    send(8'h00, 0, 0); send(8'h04, 0, 0);
    for (int w = 0; w < 1024; w++) send_word(32'h1000_0000 | 32'(w), 0, 0);
    check("full_core_rst", 64'({core_rst, done}), 64'b10);
    wait_done();
    check("full_writes", 64'(wq.size()), 64'd1024);
    if (wq.size() == 1024) begin
      check("full_first", 64'(wq[0]), {22'h0, 10'h000, 32'h1000_0000});
      check("full_last", 64'(wq[1023]), {22'h0, 10'h3FF, 32'h1000_03FF});
    end
    check("full_err", 64'(err), 64'd0);

    // reset in the middle of word 3
    pulse_start();
    send(8'h05, 0, 0); send(8'h00, 0, 0);
    for (int w = 0; w < 3; w++) send_word(32'hA0 + 32'(w), 0, 0);
    send(8'h11, 0, 0); send(8'h22, 0, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_outs", 64'(outs()), {16'h0, 1'b0, 1'b0, 10'd0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
    rst = 1'b0;
    wq.delete();
    pulse_start();
    send(8'h01, 0, 0); send(8'h00, 0, 0);
    send_word(32'hCAFEF00D, 0, 0);
    wait_done();
    check("midrst_writes", 64'(wq.size()), 64'd1);
    if (wq.size() == 1) check("midrst_w0", 64'(wq[0]), {22'h0, 10'd0, 32'hCAFEF00D});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
